// File: rtl/mod_reduce_if.sv
// Handshake bundle between the multiplier output register, mod_reduce and the result consumer.
// master drives the product/modulus and out_ready; slave is the reduction stage.
interface mod_reduce_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] prod;
  logic [N-1:0]   modulus;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   res;
  logic           err;
  logic           busy;

  modport master (
    output in_valid, prod, modulus, out_ready,
    input  in_ready, out_valid, res, err, busy
  );

  modport slave (
    input  in_valid, prod, modulus, out_ready,
    output in_ready, out_valid, res, err, busy
  );
endinterface

// File: rtl/mod_reduce.sv
// Sequential P mod M: restoring shift/conditional-subtract reduction, one product bit per clock,
// MSB first, with valid/ready handshakes on both sides.
//
// state  | meaning
// IDLE   | waiting for a product/modulus pair, in_ready high
// RUN    | shifting one product bit per clock into the remainder
// DONE   | res/err held with out_valid high until out_ready
module mod_reduce #(
  parameter int N  = 8,
  parameter int CW = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  mod_reduce_if.slave bus
);

  localparam logic [CW-1:0] CNT_INIT = CW'(2*N-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] sr_q, sr_d;
  logic [N-1:0]   mr_q, mr_d;
  logic [N-1:0]   r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   res_q, res_d;
  logic           err_q, err_d;

  // r < M is invariant, so r fits in N bits and t = 2r + bit < 2M needs only N+1 bits.
  logic [N:0]     t_w;
  logic           ge_w;
  logic [N-1:0]   diff_w;
  logic [N-1:0]   r_step_w;

  assign t_w      = {r_q, sr_q[2*N-1]};
  assign ge_w     = (t_w >= {1'b0, mr_q});
  assign diff_w   = t_w[N-1:0] - mr_q;
  assign r_step_w = ge_w ? diff_w : t_w[N-1:0];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    mr_d    = mr_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sr_d  = bus.prod;
          mr_d  = bus.modulus;
          r_d   = '0;
          cnt_d = CNT_INIT;
          if (bus.modulus == '0) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        r_d   = r_step_w;
        sr_d  = {sr_q[2*N-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_d   = r_step_w;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      mr_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      mr_q    <= mr_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs are pure decodes of the registered state.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.res       = res_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mod_reduce.sv
// Directed-vector and random-regression bench for mod_reduce at N=8.
module tb_mod_reduce;

  logic clk;
  logic rst_n;

  mod_reduce_if #(.N(8)) bus ();

  mod_reduce #(.N(8), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] prod;
    logic [7:0]  modulus;
    logic [7:0]  exp_res;
    logic        exp_err;
    int          stall;
    bit          toggle;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int busy_cnt;
    string tag;
    tag = $sformatf("vec%0d", idx);
    check({tag, " in_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.prod      = v.prod;
    bus.modulus   = v.modulus;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_cnt++;
      if (v.toggle) begin
        bus.prod     = 16'($urandom);
        bus.modulus  = 8'($urandom);
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), v.exp_err ? 32'd1 : 32'd17);
    check({tag, " busy_cycles"}, 32'(busy_cnt), v.exp_err ? 32'd0 : 32'd16);
    check({tag, " res"}, 32'(bus.res), 32'(v.exp_res));
    check({tag, " err"}, 32'(bus.err), 32'(v.exp_err));
    for (int s = 0; s < v.stall; s++) begin
      if (v.toggle) begin
        bus.prod     = 16'($urandom);
        bus.modulus  = 8'($urandom);
      end
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check({tag, " stall_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, " stall_res"}, 32'(bus.res), 32'(v.exp_res));
      check({tag, " stall_err"}, 32'(bus.err), 32'(v.exp_err));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid_after_hs"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready_after_hs"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int spurious;
    int accepts;
    int results;
    int issued;
    int cycles;
    logic take_in;
    logic take_out;
    logic [7:0] exp_q[$];
    logic [7:0] exp_r;

    vecs[0]  = '{16'd50000, 8'd251, 8'd51,  1'b0, 0, 1'b0};
    vecs[1]  = '{16'd65535, 8'd255, 8'd0,   1'b0, 0, 1'b0};
    vecs[2]  = '{16'd100,   8'd200, 8'd100, 1'b0, 0, 1'b0};
    vecs[3]  = '{16'd65535, 8'd1,   8'd0,   1'b0, 0, 1'b0};
    vecs[4]  = '{16'd0,     8'd7,   8'd0,   1'b0, 0, 1'b0};
    vecs[5]  = '{16'd1234,  8'd0,   8'd0,   1'b1, 0, 1'b0};
    vecs[6]  = '{16'd1234,  8'd0,   8'd0,   1'b1, 5, 1'b0};
    vecs[7]  = '{16'd50000, 8'd251, 8'd51,  1'b0, 5, 1'b0};
    vecs[8]  = '{16'd12345, 8'd97,  8'd26,  1'b0, 0, 1'b1};
    vecs[9]  = '{16'd65535, 8'd254, 8'd3,   1'b0, 2, 1'b1};
    vecs[10] = '{16'd40000, 8'd13,  8'd12,  1'b0, 0, 1'b0};
    vecs[11] = '{16'd255,   8'd16,  8'd15,  1'b0, 0, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.prod      = '0;
    bus.modulus   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset res", 32'(bus.res), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle in_ready", 32'(bus.in_ready), 32'd1);
      check("idle out_valid", 32'(bus.out_valid), 32'd0);
    end

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset asserted on the 8th edge counting the accept edge as 1.
    bus.prod     = 16'd50000;
    bus.modulus  = 8'd251;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("midrun busy_before_reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun_reset in_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_reset busy", 32'(bus.busy), 32'd0);
    check("midrun_reset out_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_reset res", 32'(bus.res), 32'd0);
    check("midrun_reset err", 32'(bus.err), 32'd0);
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) spurious++;
    end
    check("midrun_reset spurious_out_valid", 32'(spurious), 32'd0);
    run_vec(99, vecs[0]);

    // Random back-to-back regression with out_ready stalls.
    accepts = 0;
    results = 0;
    issued  = 0;
    cycles  = 0;
    while (results < 1000 && cycles < 60000) begin
      if (!bus.in_valid && issued < 1000) begin
        bus.prod     = 16'($urandom);
        bus.modulus  = 8'($urandom_range(1, 255));
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      take_in  = bus.in_valid && bus.in_ready;
      take_out = bus.out_valid && bus.out_ready;
      if (take_out) begin
        if (exp_q.size() == 0) begin
          check("rand result_without_accept", 32'd1, 32'd0);
        end else begin
          exp_r = exp_q.pop_front();
          check("rand res", 32'(bus.res), 32'(exp_r));
          check("rand err", 32'(bus.err), 32'd0);
        end
        results++;
      end
      if (take_in) begin
        exp_q.push_back(8'(bus.prod % 16'(bus.modulus)));
        accepts++;
        issued++;
      end
      tick();
      if (take_in) bus.in_valid = 1'b0;
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand results", 32'(results), 32'd1000);
    check("rand accepts_eq_results", 32'(accepts), 32'(results));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
